prg_window_mapper: RTL and testbench

// - Parametrised CPU-side PRG bank translator for the multicart: splits $8000-$FFFF into

---
 rtl/prg_window_mapper_if.sv | 21 ++
 rtl/prg_window_mapper.sv | 95 +++++++++
 tb/tb_prg_window_mapper.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_window_mapper_if.sv
// CPU-side cartridge bus bundle between the CPU pins and the PRG window mapper.
interface prg_window_mapper_if #(
  parameter int unsigned OUT_MSB = 26
);
  logic                romsel;
  logic                cpu_rw_in;
  logic [14:0]         cpu_addr_in;
  logic [7:0]          cpu_data_in;
  logic [OUT_MSB-13:0] cpu_addr_out;
  logic                locked;

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    input  cpu_addr_out, locked
  );

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    output cpu_addr_out, locked
  );
endinterface

// File: rtl/prg_window_mapper.sv
// PRG bank translator: per-window bank registers, menu-time base/mask with lock,
// and a read-modify-write double-write filter.
module prg_window_mapper #(
  parameter int unsigned WINDOW_BITS = 2,
  parameter int unsigned BANK_BITS   = 8,
  parameter int unsigned OUT_MSB     = 26,
  parameter int unsigned RMW_FILTER  = 1
) (
  input  logic                  m2,
  input  logic                  reset,
  prg_window_mapper_if.slave    bus
);

  localparam int unsigned WINDOWS   = 1 << WINDOW_BITS;
  localparam int unsigned LOW_BITS  = 2 - WINDOW_BITS;
  localparam int unsigned WIDX_BITS = (WINDOW_BITS == 0) ? 1 : WINDOW_BITS;
  localparam int unsigned OUT_W     = OUT_MSB - 12;
  localparam int unsigned HI_W      = OUT_MSB - 13;
  localparam int unsigned BASE_HI_W = OUT_MSB - 21;
  localparam logic [1:0]  LOW_MASK  = 2'((1 << LOW_BITS) - 1);

  typedef enum logic {ST_CONFIG, ST_LOCKED} state_e;

  state_e               state_q, state_d;
  logic [HI_W-1:0]      base_q, base_d;
  logic [7:0]           mask_q, mask_d;
  logic                 armed_q, armed_d;
  logic [BANK_BITS-1:0] bank_q [WINDOWS];
  logic [BANK_BITS-1:0] bank_d [WINDOWS];

  logic [WIDX_BITS-1:0] win_c;
  logic                 qual_wr_c, accept_c, cfg_wr_c, bank_wr_c;
  logic [OUT_W-1:0]     mapped_c;
  logic [HI_W-1:0]      hi_c;
  logic                 unused_c;

  // A14..A13 bits above the in-window field select the bank register
  always_comb begin
    win_c     = WIDX_BITS'(bus.cpu_addr_in[14:13] >> LOW_BITS);
    qual_wr_c = ~bus.cpu_rw_in;
    accept_c  = qual_wr_c && !((RMW_FILTER != 0) && armed_q);
    cfg_wr_c  = accept_c && bus.romsel && (bus.cpu_addr_in[14:12] == 3'b101)
                && (state_q == ST_CONFIG);
    bank_wr_c = accept_c && !bus.romsel;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    // Any write, even a dropped one, arms the filter for the next edge
    armed_d = qual_wr_c;
    if (cfg_wr_c) begin
      case (bus.cpu_addr_in[1:0])
        2'd0: base_d[7:0]      = bus.cpu_data_in;
        2'd1: base_d[HI_W-1:8] = BASE_HI_W'(bus.cpu_data_in);
        2'd2: mask_d           = bus.cpu_data_in;
        default: begin
          if (bus.cpu_data_in[7]) state_d = ST_LOCKED;
        end
      endcase
    end
    if (bank_wr_c) bank_d[win_c] = bus.cpu_data_in[BANK_BITS-1:0];
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      state_q <= ST_CONFIG;
      base_q  <= '0;
      mask_q  <= '0;
      armed_q <= 1'b0;
      for (int unsigned i = 0; i < WINDOWS; i++)
        bank_q[i] <= BANK_BITS'((1 << BANK_BITS) - WINDOWS + i);
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      armed_q <= armed_d;
      bank_q  <= bank_d;
    end
  end

  // Bit 13 passes straight through; bits above it are masked then based
  always_comb begin
    mapped_c = (OUT_W'(bank_q[win_c]) << LOW_BITS)
             | OUT_W'(bus.cpu_addr_in[14:13] & LOW_MASK);
    hi_c     = base_q | (mapped_c[OUT_W-1:1] & ~HI_W'(mask_q));
  end

  assign bus.cpu_addr_out = {hi_c, mapped_c[0]};
  assign bus.locked       = (state_q == ST_LOCKED);
  assign unused_c         = ^{bus.cpu_addr_in[11:2]};

endmodule

// File: tb/tb_prg_window_mapper.sv
// Directed bench for prg_window_mapper: default 4x8KB instance plus a 1x32KB instance.
module tb_prg_window_mapper;

  logic m2 = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  prg_window_mapper_if #(.OUT_MSB(26)) bus0 ();
  prg_window_mapper_if #(.OUT_MSB(26)) bus1 ();

  prg_window_mapper #(.WINDOW_BITS(2), .BANK_BITS(8), .OUT_MSB(26), .RMW_FILTER(1)) u_dut4 (
    .m2(m2), .reset(reset), .bus(bus0)
  );

  prg_window_mapper #(.WINDOW_BITS(0), .BANK_BITS(8), .OUT_MSB(26), .RMW_FILTER(1)) u_dut1 (
    .m2(m2), .reset(reset), .bus(bus1)
  );

  always #5 m2 = ~m2;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit which, input logic rs, input logic rw,
                       input logic [14:0] a, input logic [7:0] d);
    @(negedge m2);
    if (which) begin
      bus1.romsel = rs; bus1.cpu_rw_in = rw; bus1.cpu_addr_in = a; bus1.cpu_data_in = d;
    end else begin
      bus0.romsel = rs; bus0.cpu_rw_in = rw; bus0.cpu_addr_in = a; bus0.cpu_data_in = d;
    end
  endtask

  task automatic wr(input bit which, input logic rs, input logic [14:0] a, input logic [7:0] d);
    drive(which, rs, 1'b0, a, d);
  endtask

  task automatic idle(input bit which);
    drive(which, 1'b1, 1'b1, 15'h5000, 8'h00);
  endtask

  task automatic rd(input bit which, input logic [14:0] a, output logic [13:0] v);
    drive(which, 1'b0, 1'b1, a, 8'h00);
    #1;
    v = which ? bus1.cpu_addr_out : bus0.cpu_addr_out;
  endtask

  task automatic do_reset();
    @(negedge m2);
    reset = 1'b1;
    bus0.romsel = 1'b1; bus0.cpu_rw_in = 1'b1; bus0.cpu_addr_in = 15'h5000; bus0.cpu_data_in = 8'h00;
    bus1.romsel = 1'b1; bus1.cpu_rw_in = 1'b1; bus1.cpu_addr_in = 15'h5000; bus1.cpu_data_in = 8'h00;
    @(negedge m2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] v;
    logic [13:0] exp_v [4];
    logic [14:0] addrs [4];
    do_reset();
    addrs = '{15'h7FFC, 15'h0000, 15'h2000, 15'h4000};
    exp_v = '{14'h00FF, 14'h00FC, 14'h00FD, 14'h00FE};
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, addrs[i], v);
      checks++;
      if (v !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_bank addr=%h got=%h expected=%h", addrs[i], v, exp_v[i]);
      end
    end
    checks++;
    if (bus0.locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked got=%b expected=0", bus0.locked);
    end
  endtask

  task automatic test_config();
    logic [13:0] v;
    do_reset();
    wr(1'b0, 1'b1, 15'h5000, 8'h10);
    rd(1'b0, 15'h7FFC, v);
    checks++;
    if (v !== 14'h00FF) begin errors++; $display("FAIL cfg_base_lo got=%h expected=%h", v, 14'h00FF); end
    wr(1'b0, 1'b1, 15'h5002, 8'h0F);
    rd(1'b0, 15'h7FFC, v);
    checks++;
    if (v !== 14'h00E1) begin errors++; $display("FAIL cfg_mask_top got=%h expected=%h", v, 14'h00E1); end
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h00E0) begin errors++; $display("FAIL cfg_mask_bot got=%h expected=%h", v, 14'h00E0); end
    wr(1'b0, 1'b1, 15'h5001, 8'h03);
    rd(1'b0, 15'h7FFC, v);
    checks++;
    if (v !== 14'h06E1) begin errors++; $display("FAIL cfg_base_hi got=%h expected=%h", v, 14'h06E1); end
  endtask

  task automatic test_bank_write();
    logic [13:0] v;
    logic [13:0] exp_v [4];
    logic [14:0] addrs [4];
    do_reset();
    wr(1'b0, 1'b0, 15'h2000, 8'h05);
    addrs = '{15'h2000, 15'h3FFF, 15'h0000, 15'h6000};
    exp_v = '{14'h0005, 14'h0005, 14'h00FC, 14'h00FF};
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, addrs[i], v);
      checks++;
      if (v !== exp_v[i]) begin
        errors++;
        $display("FAIL bank_write addr=%h got=%h expected=%h", addrs[i], v, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] v;
    do_reset();
    wr(1'b0, 1'b0, 15'h0000, 8'h11);
    wr(1'b0, 1'b0, 15'h0000, 8'h22);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h0011) begin errors++; $display("FAIL rmw_drop got=%h expected=%h", v, 14'h0011); end
    wr(1'b0, 1'b0, 15'h0000, 8'h22);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h0022) begin errors++; $display("FAIL rmw_gap got=%h expected=%h", v, 14'h0022); end
    // Config write right after a bank write is dropped too
    wr(1'b0, 1'b0, 15'h0000, 8'h44);
    wr(1'b0, 1'b1, 15'h5000, 8'h3F);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h0044) begin errors++; $display("FAIL rmw_cfg_drop got=%h expected=%h", v, 14'h0044); end
    // A dropped write still arms the filter
    wr(1'b0, 1'b0, 15'h2000, 8'h55);
    wr(1'b0, 1'b0, 15'h4000, 8'h66);
    wr(1'b0, 1'b0, 15'h6000, 8'h77);
    rd(1'b0, 15'h2000, v);
    checks++;
    if (v !== 14'h0055) begin errors++; $display("FAIL rmw_chain_first got=%h expected=%h", v, 14'h0055); end
    rd(1'b0, 15'h4000, v);
    checks++;
    if (v !== 14'h00FE) begin errors++; $display("FAIL rmw_chain_second got=%h expected=%h", v, 14'h00FE); end
    rd(1'b0, 15'h6000, v);
    checks++;
    if (v !== 14'h00FF) begin errors++; $display("FAIL rmw_chain_third got=%h expected=%h", v, 14'h00FF); end
  endtask

  task automatic test_lock();
    logic [13:0] v;
    do_reset();
    wr(1'b0, 1'b1, 15'h5003, 8'h00);
    idle(1'b0);
    #1;
    checks++;
    if (bus0.locked !== 1'b0) begin errors++; $display("FAIL lock_bit7_clear got=%b expected=0", bus0.locked); end
    wr(1'b0, 1'b1, 15'h5003, 8'h80);
    idle(1'b0);
    #1;
    checks++;
    if (bus0.locked !== 1'b1) begin errors++; $display("FAIL lock_set got=%b expected=1", bus0.locked); end
    wr(1'b0, 1'b1, 15'h5000, 8'h3F);
    idle(1'b0);
    wr(1'b0, 1'b1, 15'h5002, 8'hFF);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h00FC) begin errors++; $display("FAIL lock_base_frozen got=%h expected=%h", v, 14'h00FC); end
    rd(1'b0, 15'h7FFC, v);
    checks++;
    if (v !== 14'h00FF) begin errors++; $display("FAIL lock_mask_frozen got=%h expected=%h", v, 14'h00FF); end
    wr(1'b0, 1'b0, 15'h0000, 8'h07);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h0007) begin errors++; $display("FAIL lock_bank_write got=%h expected=%h", v, 14'h0007); end
    do_reset();
    #1;
    checks++;
    if (bus0.locked !== 1'b0) begin errors++; $display("FAIL lock_reset got=%b expected=0", bus0.locked); end
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h00FC) begin errors++; $display("FAIL lock_reset_bank got=%h expected=%h", v, 14'h00FC); end
    wr(1'b0, 1'b1, 15'h5000, 8'h3F);
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h00FE) begin errors++; $display("FAIL unlock_base got=%h expected=%h", v, 14'h00FE); end
  endtask

  task automatic test_reset_priority();
    logic [13:0] v;
    @(negedge m2);
    reset = 1'b1;
    bus0.romsel = 1'b0; bus0.cpu_rw_in = 1'b0; bus0.cpu_addr_in = 15'h0000; bus0.cpu_data_in = 8'h99;
    @(negedge m2);
    reset = 1'b0;
    bus0.romsel = 1'b1; bus0.cpu_rw_in = 1'b1; bus0.cpu_addr_in = 15'h5000;
    rd(1'b0, 15'h0000, v);
    checks++;
    if (v !== 14'h00FC) begin errors++; $display("FAIL reset_wins got=%h expected=%h", v, 14'h00FC); end
  endtask

  task automatic test_single_window();
    logic [13:0] v;
    do_reset();
    rd(1'b1, 15'h7FFF, v);
    checks++;
    if (v !== 14'h03FF) begin errors++; $display("FAIL w0_reset_top got=%h expected=%h", v, 14'h03FF); end
    rd(1'b1, 15'h0000, v);
    checks++;
    if (v !== 14'h03FC) begin errors++; $display("FAIL w0_reset_bot got=%h expected=%h", v, 14'h03FC); end
    idle(1'b1);
    wr(1'b1, 1'b0, 15'h1234, 8'h03);
    rd(1'b1, 15'h7FFF, v);
    checks++;
    if (v !== 14'h000F) begin errors++; $display("FAIL w0_bank_top got=%h expected=%h", v, 14'h000F); end
    rd(1'b1, 15'h2000, v);
    checks++;
    if (v !== 14'h000D) begin errors++; $display("FAIL w0_bank_a13 got=%h expected=%h", v, 14'h000D); end
    idle(1'b1);
  endtask

  initial begin
    bus0.romsel = 1'b1; bus0.cpu_rw_in = 1'b1; bus0.cpu_addr_in = 15'h5000; bus0.cpu_data_in = 8'h00;
    bus1.romsel = 1'b1; bus1.cpu_rw_in = 1'b1; bus1.cpu_addr_in = 15'h5000; bus1.cpu_data_in = 8'h00;
    test_reset();
    test_config();
    test_bank_write();
    test_back_to_back();
    test_lock();
    test_reset_priority();
    test_single_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
